mac_tx_arbiter: RTL and testbench
=================================

Name: mac_tx_arbiter

Overview:
- Shares the MAC transmit word/length FIFO pair between NREQ data producers (DAQ channels, status/reply generator).
- Each producer offers length-tagged chunks of 32-bit words. The arbiter grants round-robin and copies one whole chunk at a time into the MAC data FIFO, prefixed by a header word. It then commits the chunk length into the MAC length FIFO.
- The MAC therefore only ever sees complete, atomically committed chunks, and can batch them into frames.

Parameters:
- NREQ, 4: number of requesters, 2..16.
- MAC_PACKET_BITS, 9: width of length fields (words).
- FIFO_BITS, 10: width of out_data_free.
- MAX_CHUNK, 64: largest accepted chunk length in words, excluding header.
- STALL_TIMEOUT, 255: COPY cycles without source data before padding, 1..255.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- enable, in, 1: when low, no new grant; a chunk in progress completes.
- req_len, in, NREQ*MAC_PACKET_BITS: chunk length per requester, slice i.
- req_len_valid, in, NREQ: req_len[i] valid (FWFT length FIFO not empty).
- req_len_rd_en, out, NREQ: pop requester length, 1-cycle pulse.
- req_data, in, NREQ*32: head data word per requester.
- req_data_valid, in, NREQ: req_data[i] valid.
- req_data_rd_en, out, NREQ: pop requester data word (combinational).
- out_data, out, 32: word to MAC data FIFO.
- out_data_wr_en, out, 1: write strobe.
- out_data_free, in, FIFO_BITS: free words in MAC data FIFO.
- out_len, out, MAC_PACKET_BITS: chunk length incl. header.
- out_len_wr_en, out, 1: write strobe.
- out_len_full, in, 1: MAC length FIFO full.
- err, out, NREQ: sticky per-requester error flags.
- err_clr, in, 1: clears err.
- debug, out, 16: {state[2:0], sel[3:0], rr_ptr[3:0], 5'b0}.

Behaviour:
Reset:
- All outputs 0; state=ARB; rr_ptr=NREQ-1; seq=0; err=0.
- Reset mid-chunk abandons the chunk with no length commit. The downstream FIFO is reset by the same rst_n.

ARB:
- Search order is rr_ptr+1 .. rr_ptr+NREQ modulo NREQ. Take the first i with req_len_valid[i].
- Require enable=1 and out_len_full=0 before acting.
- If len==0: pulse req_len_rd_en[i], rr_ptr<=i, stay in ARB, no output.
- If len>MAX_CHUNK: pulse req_len_rd_en[i], set err[i], rr_ptr<=i, stay in ARB. The requester's data FIFO is not touched.
- Else if out_data_free >= len+1: latch sel=i, rem=len; pulse req_len_rd_en[i]; go to HDR.
- Otherwise wait. Do not skip to a later requester; this keeps ordering and prevents starvation of large chunks.

HDR:
- Write one header word: {4'hA, sel[3:0], seq[7:0], len zero-extended to 16}.
- out_data_wr_en=1; go to COPY; stall counter reset.

COPY:
- req_data_rd_en[sel] = (state==COPY) && req_data_valid[sel].
- On a pop, next cycle out_data=req_data[sel], out_data_wr_en=1, rem--, stall counter reset.
- On no pop, the stall counter increments.
- When the stall counter reaches STALL_TIMEOUT: set err[sel], enter pad mode. Write 32'hDEADBEEF each cycle until rem=0; no further pops from the source.
- Move to COMMIT the cycle after the last word is written (rem reaches 0).

COMMIT:
- out_len=len+1, out_len_wr_en=1 (out_len_full was checked at grant; the MAC only pops).
- seq<=seq+1 (8-bit wrap); rr_ptr<=sel; go to ARB.

General rules:
- All outputs registered except req_data_rd_en.
- Latency: grant to header is 1 cycle. Throughput is 1 word/cycle while the source is valid. Per-chunk overhead is 3 cycles (ARB, HDR, COMMIT).
- err_clr and a simultaneous error set: the set wins.
- enable dropping mid-chunk has no effect until ARB.

Decomposition:
- Package mac_pkg: state encodings (ARB, HDR, COPY, COMMIT), HDR_MAGIC=4'hA, PAD_WORD=32'hDEADBEEF, header field offsets.
- Sub-module rr_pick: combinational rotate-priority encoder.
  - Inputs: request mask, rr_ptr.
  - Outputs: index, any.
  - Reused by later arbiters.

Test Plan:
- Single requester 0, len=3, words 1,2,3, free=100 → out_data A000_0003,1,2,3; then out_len=4 one cycle later; seq increments to 1.
- Requesters 0..3 all valid with len=2 continuously → grants in order 0,1,2,3,0; header sel field matches; no requester served twice in a row.
- Requester 1 len=10, out_data_free=5 → no grant and no output, even with requester 2 valid; raise free to 11 → requester 1 granted first.
- Requester 2 len=0 then len=MAX_CHUNK+1 → two length pops, zero out_data writes, err=4'b0100; err_clr → 0.
- Requester 0 len=4, supplies 1 word then deasserts valid → after 255 idle cycles, 3 words DEADBEEF, out_len=5, err[0]=1.
- Assert rst_n=0 mid-COPY → all outputs 0 asynchronously; after release, a fresh chunk uses seq=0.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC transmit arbiter.
//   - state_t       : arbiter FSM state encoding
//   - HDR_MAGIC     : tag nibble identifying a chunk header word
//   - PAD_WORD      : filler written when a source stalls mid-chunk
//   - HDR_*_LSB     : bit offsets of the header word fields
//   - make_header() : assembles {magic, sel, seq, len16}
package mac_pkg;

  typedef enum logic [2:0] {
    ST_ARB    = 3'd0,
    ST_HDR    = 3'd1,
    ST_COPY   = 3'd2,
    ST_COMMIT = 3'd3
  } state_t;

  localparam logic [3:0]  HDR_MAGIC = 4'hA;
  localparam logic [31:0] PAD_WORD  = 32'hDEADBEEF;

  localparam int HDR_MAGIC_LSB = 28;
  localparam int HDR_SEL_LSB   = 24;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int HDR_LEN_LSB   = 0;

  function automatic logic [31:0] make_header(input logic [3:0]  sel,
                                              input logic [7:0]  seq,
                                              input logic [15:0] len);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 4] = HDR_MAGIC;
    h[HDR_SEL_LSB   +: 4] = sel;
    h[HDR_SEQ_LSB   +: 8] = seq;
    h[HDR_LEN_LSB   +: 16] = len;
    return h;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
//   mask [N-1:0] : request lines
//   ptr  [IW-1:0]: last-served index; search starts at ptr+1 and wraps
//   idx  [IW-1:0]: first requesting index in search order (0 when none)
//   any          : at least one mask bit set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 4
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotating a doubled copy puts requester (ptr+1+j) mod N at bit j, so the
  // lowest set bit of rot is the winner; no variable bit-selects needed.
  always_comb begin
    dbl = {mask, mask};
    rot = N'(dbl >> (int'(ptr) + 1));
    idx = '0;
    any = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!any && rot[j]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + 1 + j) % N);
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: round-robin copier of length-tagged chunks from NREQ
// producers into the shared MAC data/length FIFO pair.
//   clk, rst_n           : clock, asynchronous active-low reset
//   enable               : permits new grants (a chunk in flight completes)
//   req_len/_valid/_rd_en: per-requester FWFT length FIFO (rd_en registered)
//   req_data/_valid/_rd_en: per-requester FWFT data FIFO (rd_en combinational)
//   out_data/_wr_en      : header + payload words to the MAC data FIFO
//   out_data_free        : free words in the MAC data FIFO
//   out_len/_wr_en       : committed chunk length (payload + header)
//   out_len_full         : MAC length FIFO full
//   err / err_clr        : sticky per-requester errors (bad length, stall)
//   debug                : {state, sel, rr_ptr, 5'b0}
module mac_tx_arbiter
  import mac_pkg::*;
#(
  parameter int NREQ            = 4,
  parameter int MAC_PACKET_BITS = 9,
  parameter int FIFO_BITS       = 10,
  parameter int MAX_CHUNK       = 64,
  parameter int STALL_TIMEOUT   = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [NREQ*MAC_PACKET_BITS-1:0] req_len,
  input  logic [NREQ-1:0]                 req_len_valid,
  output logic [NREQ-1:0]                 req_len_rd_en,
  input  logic [NREQ*32-1:0]              req_data,
  input  logic [NREQ-1:0]                 req_data_valid,
  output logic [NREQ-1:0]                 req_data_rd_en,
  output logic [31:0]                     out_data,
  output logic                            out_data_wr_en,
  input  logic [FIFO_BITS-1:0]            out_data_free,
  output logic [MAC_PACKET_BITS-1:0]      out_len,
  output logic                            out_len_wr_en,
  input  logic                            out_len_full,
  output logic [NREQ-1:0]                 err,
  input  logic                            err_clr,
  output logic [15:0]                     debug
);

  state_t                     state_reg, state_next;
  logic [3:0]                 sel_reg, sel_next;
  logic [3:0]                 rr_ptr_reg, rr_ptr_next;
  logic [7:0]                 seq_reg, seq_next;
  logic [MAC_PACKET_BITS-1:0] len_reg, len_next;
  logic [MAC_PACKET_BITS-1:0] rem_reg, rem_next;
  logic [7:0]                 stall_reg, stall_next;
  logic                       pad_reg, pad_next;
  logic [31:0]                out_data_reg, out_data_next;
  logic                       out_data_wr_en_reg, out_data_wr_en_next;
  logic [MAC_PACKET_BITS-1:0] out_len_reg, out_len_next;
  logic                       out_len_wr_en_reg, out_len_wr_en_next;
  logic [NREQ-1:0]            req_len_rd_en_reg, req_len_rd_en_next;
  logic [NREQ-1:0]            err_reg, err_next, err_set;
  logic [15:0]                debug_reg, debug_next;

  // Per-requester views padded to 16 entries so a 4-bit index always fits.
  logic [MAC_PACKET_BITS-1:0] len16 [16];
  logic [31:0]                data16 [16];
  logic [15:0]                dvalid16;

  for (genvar gi = 0; gi < 16; gi++) begin : g_slice
    if (gi < NREQ) begin : g_used
      assign len16[gi]    = req_len[gi*MAC_PACKET_BITS +: MAC_PACKET_BITS];
      assign data16[gi]   = req_data[gi*32 +: 32];
      assign dvalid16[gi] = req_data_valid[gi];
    end else begin : g_unused
      assign len16[gi]    = '0;
      assign data16[gi]   = '0;
      assign dvalid16[gi] = 1'b0;
    end
  end

  // A requester whose length pop is still in flight (registered rd_en) shows
  // its old head this cycle; hide it so the same entry is not handled twice.
  logic [NREQ-1:0]            pick_mask;
  logic [3:0]                 pick_idx;
  logic                       pick_any;
  logic [MAC_PACKET_BITS-1:0] pick_len;
  logic                       pick_fits, pick_oversize;

  assign pick_mask = req_len_valid & ~req_len_rd_en_reg;

  rr_pick #(.N(NREQ), .IW(4)) u_rr_pick (
    .mask (pick_mask),
    .ptr  (rr_ptr_reg),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign pick_len      = len16[pick_idx];
  assign pick_oversize = 32'(pick_len) > 32'(MAX_CHUNK);
  assign pick_fits     = 32'(out_data_free) >= (32'(pick_len) + 32'd1);

  logic copy_fetch;
  logic lpop_hit, len_err_hit, stall_err_hit;

  assign copy_fetch = (state_reg == ST_COPY) && !pad_reg && dvalid16[sel_reg];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign req_len_rd_en_next[gi] = lpop_hit && (pick_idx == 4'(gi));
    assign err_set[gi] = (len_err_hit && (pick_idx == 4'(gi))) ||
                         (stall_err_hit && (sel_reg == 4'(gi)));
    assign req_data_rd_en[gi] = copy_fetch && (sel_reg == 4'(gi));
  end

  // Set wins over a simultaneous clear.
  assign err_next   = (err_clr ? '0 : err_reg) | err_set;
  assign debug_next = {state_next, sel_next, rr_ptr_next, 5'b0};

  always_comb begin
    state_next          = state_reg;
    sel_next            = sel_reg;
    rr_ptr_next         = rr_ptr_reg;
    seq_next            = seq_reg;
    len_next            = len_reg;
    rem_next            = rem_reg;
    stall_next          = stall_reg;
    pad_next            = pad_reg;
    out_data_next       = out_data_reg;
    out_data_wr_en_next = 1'b0;
    out_len_next        = out_len_reg;
    out_len_wr_en_next  = 1'b0;
    lpop_hit            = 1'b0;
    len_err_hit         = 1'b0;
    stall_err_hit       = 1'b0;

    case (state_reg)
      ST_ARB: begin
        // Only the round-robin winner is considered; if it does not fit we
        // wait rather than skip, so large chunks cannot be starved.
        if (enable && !out_len_full && pick_any) begin
          if (pick_len == '0) begin
            lpop_hit    = 1'b1;
            rr_ptr_next = pick_idx;
          end else if (pick_oversize) begin
            lpop_hit    = 1'b1;
            len_err_hit = 1'b1;
            rr_ptr_next = pick_idx;
          end else if (pick_fits) begin
            lpop_hit            = 1'b1;
            sel_next            = pick_idx;
            len_next            = pick_len;
            rem_next            = pick_len;
            // Header is registered here so it lands on out_data in HDR.
            out_data_next       = make_header(pick_idx, seq_reg, 16'(pick_len));
            out_data_wr_en_next = 1'b1;
            state_next          = ST_HDR;
          end
        end
      end

      ST_HDR: begin
        stall_next = '0;
        pad_next   = 1'b0;
        state_next = ST_COPY;
      end

      ST_COPY: begin
        if (pad_reg || copy_fetch) begin
          out_data_next       = pad_reg ? PAD_WORD : data16[sel_reg];
          out_data_wr_en_next = 1'b1;
          rem_next            = rem_reg - MAC_PACKET_BITS'(1);
          stall_next          = '0;
          if (rem_reg == MAC_PACKET_BITS'(1)) state_next = ST_COMMIT;
        end else if (stall_reg == 8'(STALL_TIMEOUT - 1)) begin
          pad_next      = 1'b1;
          stall_err_hit = 1'b1;
        end else begin
          stall_next = stall_reg + 8'd1;
        end
      end

      ST_COMMIT: begin
        out_len_next       = len_reg + MAC_PACKET_BITS'(1);
        out_len_wr_en_next = 1'b1;
        seq_next           = seq_reg + 8'd1;
        rr_ptr_next        = sel_reg;
        pad_next           = 1'b0;
        state_next         = ST_ARB;
      end

      default: state_next = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= ST_ARB;
      sel_reg            <= '0;
      rr_ptr_reg         <= 4'(NREQ - 1);
      seq_reg            <= '0;
      len_reg            <= '0;
      rem_reg            <= '0;
      stall_reg          <= '0;
      pad_reg            <= 1'b0;
      out_data_reg       <= '0;
      out_data_wr_en_reg <= 1'b0;
      out_len_reg        <= '0;
      out_len_wr_en_reg  <= 1'b0;
      req_len_rd_en_reg  <= '0;
      err_reg            <= '0;
      debug_reg          <= '0;
    end else begin
      state_reg          <= state_next;
      sel_reg            <= sel_next;
      rr_ptr_reg         <= rr_ptr_next;
      seq_reg            <= seq_next;
      len_reg            <= len_next;
      rem_reg            <= rem_next;
      stall_reg          <= stall_next;
      pad_reg            <= pad_next;
      out_data_reg       <= out_data_next;
      out_data_wr_en_reg <= out_data_wr_en_next;
      out_len_reg        <= out_len_next;
      out_len_wr_en_reg  <= out_len_wr_en_next;
      req_len_rd_en_reg  <= req_len_rd_en_next;
      err_reg            <= err_next;
      debug_reg          <= debug_next;
    end
  end

  assign out_data       = out_data_reg;
  assign out_data_wr_en = out_data_wr_en_reg;
  assign out_len        = out_len_reg;
  assign out_len_wr_en  = out_len_wr_en_reg;
  assign req_len_rd_en  = req_len_rd_en_reg;
  assign err            = err_reg;
  assign debug          = debug_reg;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: directed, table-driven bench for mac_tx_arbiter.
// Requesters are modelled as FWFT FIFOs; a negedge monitor captures every
// data word, length commit and length pop for later comparison.
module tb_mac_tx_arbiter;
  localparam int NREQ = 4;
  localparam int MPB  = 9;
  localparam int FB   = 10;
  localparam int MAXC = 64;
  localparam int STO  = 255;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 err_clr = 1'b0;
  logic                 out_len_full = 1'b0;
  logic [FB-1:0]        out_data_free = 10'd100;
  logic [NREQ*MPB-1:0]  req_len;
  logic [NREQ-1:0]      req_len_valid, req_len_rd_en;
  logic [NREQ*32-1:0]   req_data;
  logic [NREQ-1:0]      req_data_valid, req_data_rd_en;
  logic [31:0]          out_data;
  logic                 out_data_wr_en;
  logic [MPB-1:0]       out_len;
  logic                 out_len_wr_en;
  logic [NREQ-1:0]      err;
  logic [15:0]          debug;

  always #5 clk = ~clk;

  mac_tx_arbiter #(
    .NREQ(NREQ), .MAC_PACKET_BITS(MPB), .FIFO_BITS(FB),
    .MAX_CHUNK(MAXC), .STALL_TIMEOUT(STO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_len(req_len), .req_len_valid(req_len_valid), .req_len_rd_en(req_len_rd_en),
    .req_data(req_data), .req_data_valid(req_data_valid), .req_data_rd_en(req_data_rd_en),
    .out_data(out_data), .out_data_wr_en(out_data_wr_en), .out_data_free(out_data_free),
    .out_len(out_len), .out_len_wr_en(out_len_wr_en), .out_len_full(out_len_full),
    .err(err), .err_clr(err_clr), .debug(debug)
  );

  // ---------------- requester FIFO models ----------------
  logic [MPB-1:0] lmem [NREQ][64];
  logic [31:0]    dmem [NREQ][256];
  int             lwp [NREQ];
  int             lrp [NREQ];
  int             dwp [NREQ];
  int             drp [NREQ];
  logic           fifo_clr = 1'b0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
    assign req_len_valid[gi]        = lrp[gi] != lwp[gi];
    assign req_len[gi*MPB +: MPB]   = lmem[gi][lrp[gi] % 64];
    assign req_data_valid[gi]       = drp[gi] != dwp[gi];
    assign req_data[gi*32 +: 32]    = dmem[gi][drp[gi] % 256];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (fifo_clr) begin
        lrp[i] <= 0;
        drp[i] <= 0;
      end else begin
        if (req_len_rd_en[i])  lrp[i] <= lrp[i] + 1;
        if (req_data_rd_en[i]) drp[i] <= drp[i] + 1;
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [31:0]    cap_d [1024];
  int             cap_cyc [1024];
  logic [MPB-1:0] cap_l [64];
  int             nd = 0;
  int             nl = 0;
  int             lpops [NREQ];
  int             cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (out_data_wr_en) begin
        cap_d[nd % 1024]   <= out_data;
        cap_cyc[nd % 1024] <= cyc;
        nd <= nd + 1;
      end
      if (out_len_wr_en) begin
        cap_l[nl % 64] <= out_len;
        nl <= nl + 1;
      end
      for (int i = 0; i < NREQ; i++)
        if (req_len_rd_en[i]) lpops[i] <= lpops[i] + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_commits(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (nl < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (nl < target) begin
      n_fail++;
      $display("FAIL %s: %0d length commits, expected %0d within %0d cycles", name, nl, target, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic push_chunk(input int r, input int len, input int nwords, input logic [31:0] base);
    lmem[r][lwp[r] % 64] = MPB'(len);
    lwp[r]++;
    for (int k = 0; k < nwords; k++) begin
      dmem[r][dwp[r] % 256] = base + 32'(k);
      dwp[r]++;
    end
  endtask

  function automatic logic [31:0] hdr(input int sel, input int seq, input int len);
    logic [31:0] h;
    h = {4'hA, 4'(sel), 8'(seq), 16'(len)};
    return h;
  endfunction

  // ---------------- table of single-chunk transactions ----------------
  typedef struct {
    int          req;
    int          len;
    int          nwords;
    logic [31:0] hdr;
    int          nwr;
    logic [8:0]  olen;
    int          ncommit;
    logic [3:0]  err;
  } vec_t;

  vec_t vt [5];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0, l0, p0, p1, p2, gap;
    logic [31:0] base;
    int rr_exp [6];

    vt[0] = '{0, 3,  3,  32'hA000_0003, 4,  9'd4,  1, 4'b0000};
    vt[1] = '{2, 1,  1,  32'hA201_0001, 2,  9'd2,  1, 4'b0000};
    vt[2] = '{3, 64, 64, 32'hA302_0040, 65, 9'd65, 1, 4'b0000};
    vt[3] = '{2, 0,  0,  32'h0,         0,  9'd0,  0, 4'b0000};
    vt[4] = '{2, 65, 0,  32'h0,         0,  9'd0,  0, 4'b0100};
    rr_exp = '{3, 0, 1, 2, 3, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst out_data", out_data, 32'h0);
    chk("rst out_data_wr_en", 32'(out_data_wr_en), 32'h0);
    chk("rst out_len", 32'(out_len), 32'h0);
    chk("rst out_len_wr_en", 32'(out_len_wr_en), 32'h0);
    chk("rst err", 32'(err), 32'h0);
    chk("rst req_len_rd_en", 32'(req_len_rd_en), 32'h0);
    chk("rst debug", 32'(debug), 32'h0);
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle debug", 32'(debug), 32'h0060);
    $display("reset: outputs idle, debug=%h", debug);

    // Table-driven single chunks
    for (int v = 0; v < 5; v++) begin
      d0 = nd; l0 = nl; p0 = lpops[vt[v].req];
      base = (32'(vt[v].req) << 16) + (32'(v) << 8) + 32'd1;
      push_chunk(vt[v].req, vt[v].len, vt[v].nwords, base);
      if (vt[v].ncommit > 0) wait_commits(l0 + 1, 300, "vec commit");
      else repeat (10) @(negedge clk);
      chk("vec data writes", 32'(nd - d0), 32'(vt[v].nwr));
      chk("vec len pops", 32'(lpops[vt[v].req] - p0), 32'd1);
      chk("vec commits", 32'(nl - l0), 32'(vt[v].ncommit));
      if (vt[v].nwr > 0) begin
        chk("vec header", cap_d[d0 % 1024], vt[v].hdr);
        for (int k = 0; k < vt[v].nwords; k++)
          chk("vec word", cap_d[(d0 + 1 + k) % 1024], base + 32'(k));
        chk("vec out_len", 32'(cap_l[l0 % 64]), 32'(vt[v].olen));
      end
      chk("vec err", 32'(err), 32'(vt[v].err));
      $display("vec %0d: req %0d len %0d -> %0d words, %0d commits, err=%b",
               v, vt[v].req, vt[v].len, nd - d0, nl - l0, err);
    end

    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'h0);
    $display("err_clr: err=%b", err);

    // Round robin: last served was requester 2, so order is 3,0,1,2,3,0
    d0 = nd; l0 = nl;
    push_chunk(3, 2, 2, 32'h3000_0000); push_chunk(3, 2, 2, 32'h3000_0010);
    push_chunk(0, 2, 2, 32'h0000_0000); push_chunk(0, 2, 2, 32'h0000_0010);
    push_chunk(1, 2, 2, 32'h1000_0000);
    push_chunk(2, 2, 2, 32'h2000_0000);
    wait_commits(l0 + 6, 200, "rr commits");
    chk("rr data writes", 32'(nd - d0), 32'd18);
    for (int k = 0; k < 6; k++) begin
      chk("rr header", cap_d[(d0 + 3 * k) % 1024], hdr(rr_exp[k], 3 + k, 2));
      chk("rr out_len", 32'(cap_l[(l0 + k) % 64]), 32'd3);
    end
    $display("rr: %0d chunks, sel order %0d %0d %0d %0d %0d %0d",
             nl - l0, cap_d[d0][27:24], cap_d[d0+3][27:24], cap_d[d0+6][27:24],
             cap_d[d0+9][27:24], cap_d[d0+12][27:24], cap_d[d0+15][27:24]);

    // Insufficient space: requester 1 must wait, requester 2 not skipped to
    out_data_free = 10'd5;
    d0 = nd; l0 = nl; p1 = lpops[1]; p2 = lpops[2];
    push_chunk(1, 10, 10, 32'h1000_0100);
    push_chunk(2, 1, 1, 32'h2000_0100);
    repeat (20) @(negedge clk);
    chk("block writes", 32'(nd - d0), 32'd0);
    chk("block pops r1", 32'(lpops[1] - p1), 32'd0);
    chk("block pops r2", 32'(lpops[2] - p2), 32'd0);
    out_data_free = 10'd11;
    wait_commits(l0 + 2, 100, "block commits");
    chk("block hdr r1", cap_d[d0 % 1024], hdr(1, 9, 10));
    chk("block hdr r2", cap_d[(d0 + 11) % 1024], hdr(2, 10, 1));
    chk("block out_len r1", 32'(cap_l[l0 % 64]), 32'd11);
    chk("block out_len r2", 32'(cap_l[(l0 + 1) % 64]), 32'd2);
    out_data_free = 10'd100;
    $display("block: held with free=5, then %0d chunks at free=11", nl - l0);

    // Source stall: 1 of 4 words, remainder padded after timeout
    d0 = nd; l0 = nl;
    push_chunk(0, 4, 1, 32'h0000_0A01);
    wait_commits(l0 + 1, 600, "stall commit");
    chk("stall writes", 32'(nd - d0), 32'd5);
    chk("stall header", cap_d[d0 % 1024], hdr(0, 11, 4));
    chk("stall word", cap_d[(d0 + 1) % 1024], 32'h0000_0A01);
    for (int k = 2; k < 5; k++)
      chk("stall pad", cap_d[(d0 + k) % 1024], 32'hDEADBEEF);
    chk("stall out_len", 32'(cap_l[l0 % 64]), 32'd5);
    chk("stall err", 32'(err), 32'b0001);
    gap = cap_cyc[(d0 + 2) % 1024] - cap_cyc[(d0 + 1) % 1024];
    chk("stall gap", 32'(gap >= STO && gap <= STO + 5), 32'd1);
    $display("stall: %0d writes, pad after %0d cycles, err=%b", nd - d0, gap, err);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Asynchronous reset mid-COPY
    d0 = nd; l0 = nl;
    push_chunk(1, 8, 2, 32'h1000_0200);
    begin
      int k;
      k = 0;
      while (nd < d0 + 3 && k < 50) begin @(negedge clk); k++; end
    end
    repeat (5) @(negedge clk);
    chk("pre-reset words", 32'(nd - d0), 32'd3);
    chk("pre-reset commits", 32'(nl - l0), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_data", out_data, 32'h0);
    chk("async rst debug", 32'(debug), 32'h0);
    chk("async rst rd_en", 32'(req_data_rd_en), 32'h0);
    fifo_clr = 1'b1;
    for (int i = 0; i < NREQ; i++) begin lwp[i] = 0; dwp[i] = 0; end
    repeat (2) @(negedge clk);
    fifo_clr = 1'b0;
    @(negedge clk);
    d0 = nd; l0 = nl;
    rst_n = 1'b1;
    push_chunk(3, 1, 1, 32'h0000_0077);
    wait_commits(l0 + 1, 50, "post-reset commit");
    repeat (10) @(negedge clk);
    chk("post-reset commits", 32'(nl - l0), 32'd1);
    chk("post-reset header", cap_d[d0 % 1024], hdr(3, 0, 1));
    chk("post-reset word", cap_d[(d0 + 1) % 1024], 32'h0000_0077);
    chk("post-reset out_len", 32'(cap_l[l0 % 64]), 32'd2);
    $display("reset mid-copy: abandoned chunk dropped, new header %h", cap_d[d0 % 1024]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
